// File: rtl/pending_request_queue_if.sv
// pending_request_queue_if: request, encoder-return and issue signals of pending_request_queue.
interface pending_request_queue_if #(parameter int WIDTH = 32);
    localparam int WIDTH_LOG = $clog2(WIDTH);
    logic [WIDTH-1:0]     req_vld;
    logic [WIDTH-1:0]     pnd_vld;
    logic [WIDTH_LOG-1:0] enc_idx;
    logic                 enc_vld;
    logic                 out_vld;
    logic [WIDTH_LOG-1:0] out_idx;
    logic                 out_rdy;
    logic                 ovf;
    logic                 ovf_clr;
    modport slave (
        input  req_vld, enc_idx, enc_vld, out_rdy, ovf_clr,
        output pnd_vld, out_vld, out_idx, ovf
    );
    modport master (
        output req_vld, enc_idx, enc_vld, out_rdy, ovf_clr,
        input  pnd_vld, out_vld, out_idx, ovf
    );
endinterface

// File: rtl/pending_request_queue.sv
// pending_request_queue: sticky request collector feeding a priority encoder,
// issuing one pending index at a time on a registered valid/ready output.
module pending_request_queue #(parameter int WIDTH = 32) (
    input logic clk,
    input logic rst,
    pending_request_queue_if.slave bus
);
    localparam int WIDTH_LOG = $clog2(WIDTH);
    logic [WIDTH-1:0]     r_pnd;
    logic [WIDTH-1:0]     w_clr;
    logic [WIDTH_LOG-1:0] r_out_idx;
    logic                 r_out_vld;
    logic                 r_ovf;
    logic                 w_slot_free;
    logic                 w_load;
    logic                 w_ovf_set;
    assign w_slot_free = !r_out_vld || bus.out_rdy;
    assign w_load      = w_slot_free && bus.enc_vld;
    assign w_clr       = w_load ? (WIDTH'(1) << bus.enc_idx) : '0;
    // a pulse on a line still pending after this cycle's issue is a lost request
    assign w_ovf_set   = |(bus.req_vld & r_pnd & ~w_clr);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pnd     <= '0;
            r_out_vld <= 1'b0;
            r_out_idx <= '0;
            r_ovf     <= 1'b0;
        end else begin
            r_pnd <= bus.req_vld | (r_pnd & ~w_clr);
            r_ovf <= w_ovf_set || (r_ovf && !bus.ovf_clr);
            if (w_slot_free) r_out_vld <= bus.enc_vld;
            if (w_load) r_out_idx <= bus.enc_idx;
        end
    end
    assign bus.pnd_vld = r_pnd;
    assign bus.out_vld = r_out_vld;
    assign bus.out_idx = r_out_idx;
    assign bus.ovf     = r_ovf;
    a_enc_idx_range: assert property (@(posedge clk) disable iff (rst)
        bus.enc_vld |-> (int'(bus.enc_idx) < WIDTH));
endmodule
